// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - PC unit opcodes and fetch sequencer state encoding
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        PC_HOLD = 2'b00,
        PC_INC  = 2'b01,
        PC_LOAD = 2'b10,
        PC_CLR  = 2'b11
    } pc_op_e;

    typedef enum logic [2:0] {
        ST_ADDR  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_FLUSH = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch control FSM driving the PC unit, imem handshake and decode handshake
module fetch_sequencer
    import fetch_sequencer_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_pc,
    output logic [1:0]  o_pc_op,
    output logic [15:0] o_pc_target,
    output logic        o_imem_req,
    output logic [15:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [15:0] i_imem_data,
    output logic [15:0] o_instr,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    input  logic        i_branch_valid,
    input  logic [15:0] i_branch_target,
    input  logic        i_halt,
    output logic        o_halted
);

    fetch_state_e state_q, state_d;
    pc_op_e       pc_op_q, pc_op_d;
    logic [15:0]  pc_target_q, pc_target_d;
    logic         imem_req_q, imem_req_d;
    logic [15:0]  imem_addr_q, imem_addr_d;
    logic [15:0]  instr_q, instr_d;
    logic         instr_valid_q, instr_valid_d;
    logic         halted_q, halted_d;
    logic         halt_pend_q, halt_pend_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= ST_ADDR;
            pc_op_q       <= PC_CLR;
            pc_target_q   <= 16'h0000;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= 16'h0000;
            instr_q       <= 16'h0000;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            halt_pend_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_op_q       <= pc_op_d;
            pc_target_q   <= pc_target_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
            halt_pend_q   <= halt_pend_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_op_d       = PC_HOLD;
        pc_target_d   = pc_target_q;
        imem_req_d    = imem_req_q;
        imem_addr_d   = imem_addr_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;
        halt_pend_d   = halt_pend_q;

        case (state_q)
            ST_ADDR: begin
                if (i_halt) begin
                    state_d       = ST_HALT;
                    instr_valid_d = 1'b0;
                    halted_d      = 1'b1;
                end else if (i_branch_valid) begin
                    pc_op_d     = PC_LOAD;
                    pc_target_d = i_branch_target;
                end else begin
                    imem_addr_d = i_pc;
                    imem_req_d  = 1'b1;
                    state_d     = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (i_imem_ack) begin
                    imem_req_d = 1'b0;
                    if (i_halt) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end else if (i_branch_valid) begin
                        pc_op_d     = PC_LOAD;
                        pc_target_d = i_branch_target;
                        state_d     = ST_ADDR;
                    end else begin
                        instr_d       = i_imem_data;
                        instr_valid_d = 1'b1;
                        state_d       = ST_ISSUE;
                    end
                end else if (i_halt) begin
                    halt_pend_d = 1'b1;
                    state_d     = ST_FLUSH;
                end else if (i_branch_valid) begin
                    pc_op_d     = PC_LOAD;
                    pc_target_d = i_branch_target;
                    state_d     = ST_FLUSH;
                end
            end
            ST_ISSUE: begin
                if (i_halt) begin
                    state_d       = ST_HALT;
                    instr_valid_d = 1'b0;
                    halted_d      = 1'b1;
                end else if (i_branch_valid) begin
                    instr_valid_d = 1'b0;
                    pc_op_d       = PC_LOAD;
                    pc_target_d   = i_branch_target;
                    state_d       = ST_ADDR;
                end else if (i_instr_ready) begin
                    instr_valid_d = 1'b0;
                    pc_op_d       = PC_INC;
                    state_d       = ST_ADDR;
                end
            end
            ST_FLUSH: begin
                // A pending halt suppresses further redirects; the abandoned fetch must still complete.
                if (i_halt) begin
                    halt_pend_d = 1'b1;
                end else if (i_branch_valid && !halt_pend_q) begin
                    pc_op_d     = PC_LOAD;
                    pc_target_d = i_branch_target;
                end
                if (i_imem_ack) begin
                    imem_req_d = 1'b0;
                    if (i_halt || halt_pend_q) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_HALT: begin
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
                halted_d      = 1'b1;
            end
            default: begin
                state_d = ST_ADDR;
            end
        endcase
    end

    assign o_pc_op       = pc_op_q;
    assign o_pc_target   = pc_target_q;
    assign o_imem_req    = imem_req_q;
    assign o_imem_addr   = imem_addr_q;
    assign o_instr       = instr_q;
    assign o_instr_valid = instr_valid_q;
    assign o_halted      = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized scoreboard bench for fetch_sequencer with PC unit and memory models
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [15:0] i_pc;
    logic [1:0]  o_pc_op;
    logic [15:0] o_pc_target;
    logic        o_imem_req;
    logic [15:0] o_imem_addr;
    logic        i_imem_ack;
    logic [15:0] i_imem_data;
    logic [15:0] o_instr;
    logic        o_instr_valid;
    logic        i_instr_ready;
    logic        i_branch_valid;
    logic [15:0] i_branch_target;
    logic        i_halt;
    logic        o_halted;

    int total = 0;
    int bad   = 0;
    int n_acc = 0;

    int ready_pct, br_pct, max_delay, spur_on;
    bit halt_sent;
    bit pending;
    int wait_cnt;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_pc           (i_pc),
        .o_pc_op        (o_pc_op),
        .o_pc_target    (o_pc_target),
        .o_imem_req     (o_imem_req),
        .o_imem_addr    (o_imem_addr),
        .i_imem_ack     (i_imem_ack),
        .i_imem_data    (i_imem_data),
        .o_instr        (o_instr),
        .o_instr_valid  (o_instr_valid),
        .i_instr_ready  (i_instr_ready),
        .i_branch_valid (i_branch_valid),
        .i_branch_target(i_branch_target),
        .i_halt         (i_halt),
        .o_halted       (o_halted)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // PC unit: applies the opcode on the falling edge, wrapping naturally at 16 bits.
    initial begin
        i_pc = 16'h1234;
        forever begin
            @(negedge clk);
            case (o_pc_op)
                2'b01:   i_pc = i_pc + 16'h1;
                2'b10:   i_pc = o_pc_target;
                2'b11:   i_pc = 16'h0000;
                default: i_pc = i_pc;
            endcase
        end
    end

    task automatic drive_cycle();
        @(negedge clk);
        if (!o_imem_req) begin
            pending     = 1'b0;
            i_imem_ack  = (spur_on != 0) && ($urandom_range(7) == 0);
            i_imem_data = 16'($urandom);
        end else begin
            if (!pending) begin
                pending  = 1'b1;
                wait_cnt = $urandom_range(max_delay);
            end
            if (wait_cnt == 0) begin
                i_imem_ack  = 1'b1;
                i_imem_data = mem_word(o_imem_addr);
                pending     = 1'b0;
            end else begin
                i_imem_ack  = 1'b0;
                i_imem_data = 16'($urandom);
                wait_cnt--;
            end
        end
        i_instr_ready   = ($urandom_range(99) < ready_pct);
        i_branch_valid  = !halt_sent && !i_rst && ($urandom_range(99) < br_pct);
        i_branch_target = 16'($urandom);
        i_halt          = 1'b0;
    endtask

    task automatic do_reset();
        i_rst     = 1'b1;
        halt_sent = 1'b0;
        repeat (2) drive_cycle();
        drive_cycle();
        i_rst = 1'b0;
    endtask

    // Reference model: expected fetch addresses, delivered data and PC opcodes from program-order rules.
    logic [15:0] exp_q[$];
    logic [15:0] cur_addr;
    logic [15:0] exp_addr;
    logic [1:0]  exp_op;
    bit          live, halted_m;
    int          hcnt;
    logic        p_req, p_valid;
    logic [15:0] p_instr;

    initial begin
        p_req = 1'b0; p_valid = 1'b0; p_instr = 16'h0;
        live = 1'b0; halted_m = 1'b0; hcnt = 0; cur_addr = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            if (i_rst) begin
                exp_q.delete();
                exp_q.push_back(16'h0000);
                live     = 1'b0;
                halted_m = 1'b0;
                hcnt     = 0;
                chk("rst_pc_op", 32'(o_pc_op), 32'd3);
                chk("rst_req", 32'(o_imem_req), 32'd0);
                chk("rst_valid", 32'(o_instr_valid), 32'd0);
                chk("rst_halted", 32'(o_halted), 32'd0);
                chk("rst_addr", 32'(o_imem_addr), 32'd0);
                chk("rst_instr", 32'(o_instr), 32'd0);
                chk("rst_target", 32'(o_pc_target), 32'd0);
            end else begin
                exp_op = 2'b00;
                if (halted_m) begin
                    hcnt++;
                end else if (i_halt) begin
                    halted_m = 1'b1;
                    hcnt     = 0;
                    live     = 1'b0;
                    exp_q.delete();
                end else if (i_branch_valid) begin
                    exp_q.delete();
                    exp_q.push_back(i_branch_target);
                    live   = 1'b0;
                    exp_op = 2'b10;
                    chk("branch_target", 32'(o_pc_target), 32'(i_branch_target));
                end else if (p_valid && i_instr_ready) begin
                    chk("accept_instr", 32'(p_instr), 32'(mem_word(cur_addr)));
                    exp_q.push_back(cur_addr + 16'h1);
                    live   = 1'b0;
                    exp_op = 2'b01;
                    n_acc++;
                end
                chk("pc_op", 32'(o_pc_op), 32'(exp_op));

                if (!p_req && o_imem_req) begin
                    if (exp_q.size() == 0) begin
                        chk("req_allowed", 32'(o_imem_req), 32'd0);
                    end else begin
                        exp_addr = exp_q.pop_front();
                        chk("fetch_addr", 32'(o_imem_addr), 32'(exp_addr));
                        cur_addr = exp_addr;
                        live     = 1'b1;
                    end
                end else if (p_req && o_imem_req) begin
                    chk("addr_stable", 32'(o_imem_addr), 32'(cur_addr));
                end
                if (p_req && !o_imem_req)
                    chk("req_until_ack", 32'(i_imem_ack), 32'd1);

                if (o_instr_valid) begin
                    chk("valid_allowed", 32'(o_instr_valid), 32'(live));
                    chk("instr_data", 32'(o_instr), 32'(mem_word(cur_addr)));
                end
                if (p_valid && !i_halt && !i_branch_valid && !i_instr_ready)
                    chk("valid_held", 32'(o_instr_valid), 32'd1);

                if (halted_m) begin
                    chk("halt_valid", 32'(o_instr_valid), 32'd0);
                    if (hcnt >= 12) begin
                        chk("halted", 32'(o_halted), 32'd1);
                        chk("halt_req", 32'(o_imem_req), 32'd0);
                    end
                end else begin
                    chk("not_halted", 32'(o_halted), 32'd0);
                end
            end
            p_req   = o_imem_req;
            p_valid = o_instr_valid;
            p_instr = o_instr;
        end
    end

    initial begin
        i_rst = 1'b1; i_imem_ack = 1'b0; i_imem_data = 16'h0;
        i_instr_ready = 1'b0; i_branch_valid = 1'b0; i_branch_target = 16'h0; i_halt = 1'b0;
        halt_sent = 1'b0; pending = 1'b0; wait_cnt = 0;
        ready_pct = 100; br_pct = 0; max_delay = 0; spur_on = 0;

        do_reset();
        repeat (30) drive_cycle();

        ready_pct = 60; br_pct = 5; max_delay = 4; spur_on = 1;
        repeat (600) drive_cycle();

        ready_pct = 30; br_pct = 20; max_delay = 4;
        repeat (300) drive_cycle();

        for (int k = 0; k < 10; k++) begin
            ready_pct = 40 + 6 * k;
            br_pct    = (k % 3) * 5;
            max_delay = k % 5;
            do_reset();
            repeat ($urandom_range(40, 5)) drive_cycle();
            drive_cycle();
            i_halt = 1'b1;
            if (k % 2 == 1) begin
                i_branch_valid  = 1'b1;
                i_branch_target = 16'($urandom);
            end
            halt_sent = 1'b1;
            repeat (20) drive_cycle();
        end

        i_rst = 1'b1;
        repeat (2) drive_cycle();
        chk("accepted_some", 32'(n_acc > 0), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
